// File: rtl/apb_uart_init_seq.sv
// APB master that initialises the UART register block and then turns
// single-byte transmit requests into LSR polls followed by a THR write.
module apb_uart_init_seq #(
    parameter logic [15:0] DIVISOR = 16'd27,
    parameter logic [7:0]  LCR_CFG = 8'h03,
    parameter logic [7:0]  FCR_CFG = 8'h07,
    parameter logic [7:0]  MCR_CFG = 8'h00,
    parameter logic [7:0]  IER_CFG = 8'h00,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic        apb_pclk,
    input  logic        apb_presetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic [11:0] m_paddr,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_pwdata,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr
);

    localparam logic [11:0] A_THR = 12'h000;
    localparam logic [11:0] A_DLL = 12'h000;
    localparam logic [11:0] A_IER = 12'h004;
    localparam logic [11:0] A_DLH = 12'h004;
    localparam logic [11:0] A_FCR = 12'h008;
    localparam logic [11:0] A_LCR = 12'h00C;
    localparam logic [11:0] A_MCR = 12'h010;
    localparam logic [11:0] A_LSR = 12'h014;
    localparam logic [11:0] A_SCR = 12'h01C;
    localparam logic [3:0]  LAST_STEP = 4'd8;
    localparam logic [7:0]  SCR_PAT   = 8'h5A;

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_ACCESS, S_READY, S_POLL_SETUP, S_POLL_ACCESS,
        S_THR_SETUP, S_THR_ACCESS, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [7:0]  txb_q, txb_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        done_q, done_d;
    logic        psel_q, psel_d;
    logic        pen_q, pen_d;
    logic        pwr_q, pwr_d;
    logic [11:0] paddr_q, paddr_d;
    logic [7:0]  pwdata_q, pwdata_d;
    logic        busy_q, busy_d;
    logic        txrdy_q, txrdy_d;

    logic [11:0] cmd_addr;
    logic        cmd_wr;
    logic [7:0]  cmd_data;
    logic        tmo_hit;
    logic        unused_prdata;

    // Only the low byte of read data carries UART register content.
    assign unused_prdata = ^{m_prdata[31:8], m_prdata[7:6], m_prdata[4:0]};

    // Last permitted ACCESS cycle: no further wait cycle may be entered.
    assign tmo_hit = ({1'b0, tcnt_q} + 9'd1) >= {1'b0, TIMEOUT};

    // Next state, step/timeout counters, byte latch and error status.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tcnt_d  = tcnt_q;
        txb_d   = txb_q;
        err_d   = err_q;
        code_d  = code_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_READY, S_ERROR: begin
                if (start) begin
                    state_d = S_SETUP;
                    step_d  = 4'd0;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                    done_d  = 1'b0;
                end else if (state_q == S_READY && tx_valid) begin
                    txb_d   = tx_data;
                    state_d = S_POLL_SETUP;
                end
            end
            S_SETUP: begin
                tcnt_d  = 8'd0;
                state_d = S_ACCESS;
            end
            S_POLL_SETUP: begin
                tcnt_d  = 8'd0;
                state_d = S_POLL_ACCESS;
            end
            S_THR_SETUP: begin
                tcnt_d  = 8'd0;
                state_d = S_THR_ACCESS;
            end
            S_ACCESS, S_POLL_ACCESS, S_THR_ACCESS: begin
                if (m_pready) begin
                    if (m_pslverr) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else if (state_q == S_POLL_ACCESS) begin
                        state_d = m_prdata[5] ? S_THR_SETUP : S_POLL_SETUP;
                    end else if (state_q == S_THR_ACCESS) begin
                        state_d = S_READY;
                    end else if (step_q == LAST_STEP) begin
                        if (m_prdata[7:0] == SCR_PAT) begin
                            state_d = S_READY;
                        end else begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                            code_d  = 2'd3;
                        end
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = S_SETUP;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERROR) done_d = 1'b0;
        if (state_d == S_READY) done_d = 1'b1;
    end

    // Init step table: address, direction and data of each transfer.
    always_comb begin
        cmd_addr = A_LCR;
        cmd_wr   = 1'b1;
        cmd_data = 8'h00;
        case (step_d)
            4'd0: begin cmd_addr = A_LCR; cmd_data = 8'h80;            end
            4'd1: begin cmd_addr = A_DLL; cmd_data = DIVISOR[7:0];     end
            4'd2: begin cmd_addr = A_DLH; cmd_data = DIVISOR[15:8];    end
            4'd3: begin cmd_addr = A_LCR; cmd_data = LCR_CFG & 8'h7F;  end
            4'd4: begin cmd_addr = A_FCR; cmd_data = FCR_CFG;          end
            4'd5: begin cmd_addr = A_MCR; cmd_data = MCR_CFG;          end
            4'd6: begin cmd_addr = A_IER; cmd_data = IER_CFG;          end
            4'd7: begin cmd_addr = A_SCR; cmd_data = SCR_PAT;          end
            4'd8: begin cmd_addr = A_SCR; cmd_wr = 1'b0;               end
            default: begin cmd_addr = A_LCR; cmd_wr = 1'b0;            end
        endcase
    end

    // Registered bus and status outputs decoded from the next state; the
    // address/data are only reloaded on a SETUP so they hold through ACCESS.
    always_comb begin
        psel_d   = 1'b0;
        pen_d    = 1'b0;
        paddr_d  = paddr_q;
        pwr_d    = pwr_q;
        pwdata_d = pwdata_q;
        case (state_d)
            S_SETUP: begin
                psel_d   = 1'b1;
                paddr_d  = cmd_addr;
                pwr_d    = cmd_wr;
                pwdata_d = cmd_data;
            end
            S_POLL_SETUP: begin
                psel_d   = 1'b1;
                paddr_d  = A_LSR;
                pwr_d    = 1'b0;
                pwdata_d = 8'h00;
            end
            S_THR_SETUP: begin
                psel_d   = 1'b1;
                paddr_d  = A_THR;
                pwr_d    = 1'b1;
                pwdata_d = txb_d;
            end
            S_ACCESS, S_POLL_ACCESS, S_THR_ACCESS: begin
                psel_d = 1'b1;
                pen_d  = 1'b1;
            end
            default: ;
        endcase
        busy_d  = psel_d;
        txrdy_d = (state_d == S_READY);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge apb_pclk) begin
        if (!apb_presetn) begin
            state_q  <= S_IDLE;
            step_q   <= 4'd0;
            tcnt_q   <= 8'd0;
            txb_q    <= 8'd0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
            done_q   <= 1'b0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwr_q    <= 1'b0;
            paddr_q  <= 12'd0;
            pwdata_q <= 8'd0;
            busy_q   <= 1'b0;
            txrdy_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            tcnt_q   <= tcnt_d;
            txb_q    <= txb_d;
            err_q    <= err_d;
            code_q   <= code_d;
            done_q   <= done_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
            pwr_q    <= pwr_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            busy_q   <= busy_d;
            txrdy_q  <= txrdy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign tx_ready  = txrdy_q;
    assign m_paddr   = paddr_q;
    assign m_psel    = psel_q;
    assign m_penable = pen_q;
    assign m_pwrite  = pwr_q;
    assign m_pwdata  = {24'h0, pwdata_q};

endmodule

// File: tb/tb_apb_uart_init_seq.sv
// Randomised bench: APB slave model with random wait states, a transfer
// log, and expected sequences/latencies derived from the register map.
module tb_apb_uart_init_seq;

    logic        apb_pclk = 1'b0;
    logic        apb_presetn, start, tx_valid;
    logic [7:0]  tx_data;
    logic        busy, done, err, tx_ready;
    logic [1:0]  err_code;
    logic [11:0] m_paddr;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [31:0] m_pwdata, m_prdata;

    apb_uart_init_seq dut (
        .apb_pclk(apb_pclk), .apb_presetn(apb_presetn), .start(start),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    always #5 apb_pclk = ~apb_pclk;

    int n_chk = 0, n_fail = 0;

    // slave configuration (written by the stimulus only)
    int         wait_max = 0, hang_at = -1, long_at = -1, slverr_at = -1;
    int         lsr_ready_at = 0;
    logic [7:0] scr_rd = 8'h5A;

    // slave/monitor state (written by the monitor only)
    int          nxfer = 0, lsr_reads = 0, wcnt = 0, wait_cur = 0, acc_run = 0, stab_bad = 0;
    logic [11:0] su_addr;
    logic        su_wr;
    logic [31:0] su_data;
    logic [31:0] noise = 32'h0;
    logic [44:0] xlog[$];
    int          wlog[$];

    logic [44:0] exp_init[9];

    assign m_pready  = m_psel && m_penable && (wcnt == wait_cur);
    assign m_pslverr = m_pready && (nxfer == slverr_at);
    assign m_prdata  = (m_paddr == 12'h01C) ? {noise[31:8], scr_rd} :
                       (m_paddr == 12'h014) ? {noise[31:8], (lsr_reads < lsr_ready_at) ?
                                               (noise[7:0] & 8'hDF) : (noise[7:0] | 8'h20)} :
                       noise;

    always @(posedge apb_pclk) begin : mon
        int inc;
        inc = 0;
        noise <= $urandom;
        if (m_pwdata[31:8] != 24'h0) inc = inc + 1;
        if (m_psel && !m_penable) begin
            wcnt    <= 0;
            acc_run <= 0;
            su_addr <= m_paddr;
            su_wr   <= m_pwrite;
            su_data <= m_pwdata;
            if (nxfer == hang_at)      wait_cur <= 100000;
            else if (nxfer == long_at) wait_cur <= 254;
            else                       wait_cur <= int'($urandom_range(wait_max, 0));
        end else if (m_psel && m_penable) begin
            acc_run <= acc_run + 1;
            if ({m_paddr, m_pwrite, m_pwdata} != {su_addr, su_wr, su_data}) inc = inc + 1;
            if (m_pready) begin
                if (apb_presetn) begin
                    xlog.push_back({m_paddr, m_pwrite, m_pwrite ? m_pwdata : 32'h0});
                    wlog.push_back(wcnt);
                    nxfer <= nxfer + 1;
                    if (!m_pwrite && m_paddr == 12'h014) lsr_reads <= lsr_reads + 1;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end
        stab_bad <= stab_bad + inc;
    end

    task automatic tick;
        @(posedge apb_pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] log_at(input int i);
        if (i < xlog.size()) return 64'(xlog[i]);
        return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic int wsum(input int base, input int n);
        int s = 0;
        for (int i = 0; i < n; i++)
            if (base + i < wlog.size()) s += wlog[base + i];
        return s;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk(tag, 64'({busy, done, err, err_code, tx_ready, m_psel, m_penable, m_pwrite,
                      m_paddr, m_pwdata}), 64'd0);
    endtask

    task automatic run_init(input string tag, input bit stray, input bit with_tx);
        int base, n;
        base  = xlog.size();
        start = 1'b1;
        if (with_tx) begin tx_valid = 1'b1; tx_data = 8'h77; end
        tick;
        start = 1'b0; tx_valid = 1'b0; n = 1;
        while (!done && !err && n < 5000) begin
            start = stray && (n == 6);
            tick;
            n++;
        end
        start = 1'b0;
        chk($sformatf("%s:done", tag), 64'(done), 64'd1);
        chk($sformatf("%s:status", tag), 64'({err, busy, tx_ready}), 64'b001);
        chk($sformatf("%s:nxfer", tag), 64'(xlog.size() - base), 64'd9);
        chk($sformatf("%s:latency", tag), 64'(n), 64'(19 + wsum(base, 9)));
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s:xfer%0d", tag, i), log_at(base + i), 64'(exp_init[i]));
    endtask

    task automatic run_tx(input logic [7:0] b, input int nbusy);
        int base, n;
        base = xlog.size();
        lsr_ready_at = lsr_reads + nbusy;
        chk("tx:ready_before", 64'(tx_ready), 64'd1);
        tx_valid = 1'b1; tx_data = b;
        tick;
        tx_valid = 1'b0; tx_data = 8'($urandom); n = 1;
        chk("tx:ready_low", 64'({tx_ready, busy}), 64'b01);
        while (!tx_ready && !err && n < 5000) begin tick; n++; end
        chk("tx:nxfer", 64'(xlog.size() - base), 64'(nbusy + 2));
        chk("tx:latency", 64'(n), 64'(5 + 2 * nbusy + wsum(base, nbusy + 2)));
        for (int i = 0; i <= nbusy; i++)
            chk($sformatf("tx:poll%0d", i), log_at(base + i), 64'({12'h014, 1'b0, 32'h0}));
        chk("tx:thr", log_at(base + nbusy + 1), 64'({12'h000, 1'b1, 24'h0, b}));
        chk("tx:done_err", 64'({done, err}), 64'b10);
    endtask

    task automatic run_err(input string tag, input int code, input int nexp, output int acc);
        int base, n, psel_seen;
        base  = xlog.size();
        start = 1'b1;
        tick;
        start = 1'b0; n = 1;
        while (!err && n < 5000) begin tick; n++; end
        acc = acc_run;
        chk($sformatf("%s:err", tag), 64'({err, err_code}), 64'({1'b1, 2'(code)}));
        chk($sformatf("%s:flags", tag), 64'({done, tx_ready, busy, m_psel}), 64'd0);
        chk($sformatf("%s:nxfer", tag), 64'(xlog.size() - base), 64'(nexp));
        psel_seen = 0;
        tx_valid = 1'b1; tx_data = 8'hC3;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (m_psel || tx_ready) psel_seen++;
        end
        tx_valid = 1'b0;
        chk($sformatf("%s:quiet", tag), 64'(psel_seen), 64'd0);
        chk($sformatf("%s:nxfer_after", tag), 64'(xlog.size() - base), 64'(nexp));
    endtask

    initial begin : stim
        int acc, k, base, n;
        exp_init[0] = {12'h00C, 1'b1, 32'h80};
        exp_init[1] = {12'h000, 1'b1, 32'h1B};
        exp_init[2] = {12'h004, 1'b1, 32'h00};
        exp_init[3] = {12'h00C, 1'b1, 32'h03};
        exp_init[4] = {12'h008, 1'b1, 32'h07};
        exp_init[5] = {12'h010, 1'b1, 32'h00};
        exp_init[6] = {12'h004, 1'b1, 32'h00};
        exp_init[7] = {12'h01C, 1'b1, 32'h5A};
        exp_init[8] = {12'h01C, 1'b0, 32'h00};

        apb_presetn = 1'b0; start = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) tick;
        chk_idle_outputs("reset");
        apb_presetn = 1'b1;
        tick;

        // zero-wait slave: exact latencies
        wait_max = 0;
        run_init("init0", 1'b0, 1'b0);
        run_tx(8'h41, 3);
        run_tx(8'($urandom), 0);

        // random waits, restarts from READY, stray starts while busy
        wait_max = 3;
        for (int r = 0; r < 4; r++) begin
            run_init($sformatf("init_r%0d", r), r[0], 1'b0);
            for (int t = 0; t < 3; t++) run_tx(8'($urandom), int'($urandom_range(4, 0)));
        end

        // start and tx_valid together in READY: start wins
        run_init("start_wins", 1'b0, 1'b1);

        // ACCESS of exactly TIMEOUT cycles still completes
        long_at = xlog.size() + int'($urandom_range(8, 0));
        run_init("tmo_edge", 1'b0, 1'b0);
        long_at = -1;

        // slave error on step 3, then a full rerun
        slverr_at = xlog.size() + 3;
        run_err("slverr", 1, 4, acc);
        slverr_at = -1;
        run_init("after_slverr", 1'b0, 1'b0);

        // scratch mismatch
        scr_rd = 8'hA5;
        run_err("scr", 3, 9, acc);
        scr_rd = 8'h5A;
        run_init("after_scr", 1'b0, 1'b0);

        // slave never ready
        k = int'($urandom_range(8, 0));
        hang_at = xlog.size() + k;
        run_err("tmo", 2, k, acc);
        chk("tmo:access_cycles", 64'(acc), 64'd255);
        hang_at = -1;

        // reset during step 5 ACCESS
        wait_max = 2;
        base = xlog.size();
        start = 1'b1;
        tick;
        start = 1'b0; n = 1;
        while (!(nxfer == base + 5 && m_psel && m_penable) && n < 5000) begin
            start = (n == 3);
            tick;
            n++;
        end
        start = 1'b0;
        chk("rst:reached_step5", 64'({m_psel, m_penable, 32'(nxfer - base)}), 64'({2'b11, 32'd5}));
        apb_presetn = 1'b0;
        tick;
        chk_idle_outputs("rst:outputs");
        apb_presetn = 1'b1;
        tick;
        chk("rst:partial", 64'(xlog.size() - base), 64'd5);
        run_init("after_rst", 1'b1, 1'b0);
        run_tx(8'($urandom), int'($urandom_range(2, 0)));

        chk("apb_stable", 64'(stab_bad), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
